// File: rtl/fetch_if.sv
// Fetch control bus: instruction-memory port, redirect request, start/status
// and the decoded-side handshake, bundled for the fetch controller.
interface fetch_if;
  logic        start;
  logic [7:0]  pc_out;
  logic [18:0] instr_in;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_instr;
  logic [7:0]  out_pc;
  logic        halted;
  logic        addr_err;

  // Fetch controller side
  modport master (
    input  start,
    input  instr_in,
    input  redirect_valid,
    input  redirect_pc,
    input  out_ready,
    output pc_out,
    output out_valid,
    output out_instr,
    output out_pc,
    output halted,
    output addr_err
  );

  // Environment side: instruction memory, redirect source and decode stage
  modport slave (
    output start,
    output instr_in,
    output redirect_valid,
    output redirect_pc,
    output out_ready,
    input  pc_out,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  halted,
    input  addr_err
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the instruction-memory address, captures
// the returned word into a 2-entry buffer toward decode, and handles start,
// halt opcode and branch/jump redirects (with out-of-range detection).
module fetch_ctrl #(
  parameter int         MEM_DEPTH = 26,
  parameter logic [7:0] RESET_PC  = 8'd0,
  parameter logic [4:0] HALT_OP   = 5'h1F
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  // Highest valid instruction address; anything above it is out of range.
  localparam logic [7:0] LAST_PC = 8'(MEM_DEPTH - 1);

  logic [1:0]  state;
  logic [7:0]  fetch_pc;
  logic [1:0]  count;
  logic [7:0]  head_pc;
  logic [18:0] head_instr;
  logic [7:0]  tail_pc;
  logic [18:0] tail_instr;
  logic        addr_err_q;

  logic        redir;
  logic        redir_oob;
  logic        pop;
  logic        push;
  logic        push_halt;

  // Sequential address advance with wrap at the end of instruction memory.
  function automatic logic [7:0] next_pc(input logic [7:0] pc);
    if (pc == LAST_PC) begin
      return 8'd0;
    end
    return pc + 8'd1;
  endfunction

  // Handshake and buffer-write decisions for this cycle.
  always_comb begin
    redir     = bus.redirect_valid;
    redir_oob = bus.redirect_valid && (bus.redirect_pc > LAST_PC);
    pop       = (count != 2'd0) && bus.out_ready;
    // A redirect flushes the buffer, so nothing fetched this cycle is kept.
    push      = (state == RUN) && !redir && ((count != 2'd2) || pop);
    push_halt = push && (bus.instr_in[4:0] == HALT_OP);
  end

  // Controller state: IDLE until start, RUN while fetching, HALTED after a halt word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (redir) begin
      // A redirect revives a halted fetcher, but does not start an idle one.
      if (state != IDLE || bus.start) begin
        state <= RUN;
      end
    end else begin
      case (state)
        IDLE:    if (bus.start) state <= RUN;
        RUN:     if (push_halt) state <= HALTED;
        HALTED:  if (bus.start) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  // Fetch address: redirect target (clamped to 0 when out of range) or advance on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redir) begin
      fetch_pc <= redir_oob ? 8'd0 : bus.redirect_pc;
    end else if (push) begin
      fetch_pc <= next_pc(fetch_pc);
    end
  end

  // Buffer occupancy: flush on redirect, otherwise net of push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else if (redir) begin
      count <= 2'd0;
    end else if (push && !pop) begin
      count <= count + 2'd1;
    end else if (pop && !push) begin
      count <= count - 2'd1;
    end
  end

  // Buffer storage as head/tail registers; the head keeps its last value when
  // the buffer empties so out_instr/out_pc hold steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_pc    <= 8'd0;
      head_instr <= 19'd0;
      tail_pc    <= 8'd0;
      tail_instr <= 19'd0;
    end else if (!redir) begin
      if (push) begin
        if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
          head_pc    <= fetch_pc;
          head_instr <= bus.instr_in;
        end else if (count == 2'd1) begin
          tail_pc    <= fetch_pc;
          tail_instr <= bus.instr_in;
        end else begin
          // Full with a pop: shift tail forward and refill tail.
          head_pc    <= tail_pc;
          head_instr <= tail_instr;
          tail_pc    <= fetch_pc;
          tail_instr <= bus.instr_in;
        end
      end else if (pop && (count == 2'd2)) begin
        head_pc    <= tail_pc;
        head_instr <= tail_instr;
      end
    end
  end

  // One-cycle error flag for a redirect outside instruction memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= redir_oob;
    end
  end

  // Output drive.
  always_comb begin
    bus.pc_out    = fetch_pc;
    bus.out_valid = (count != 2'd0);
    bus.out_pc    = head_pc;
    bus.out_instr = head_instr;
    bus.halted    = (state == HALTED);
    bus.addr_err  = addr_err_q;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational instruction-memory model.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic halt_en = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  fetch_if bus ();

  fetch_ctrl #(
    .MEM_DEPTH(26),
    .RESET_PC (8'd0),
    .HALT_OP  (5'h1F)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory word: {6'h2A, address, opcode}; opcode is addr[3:0] unless the halt word is enabled at 5.
  always_comb begin
    bus.instr_in = {6'h2A, bus.pc_out, 1'b0, bus.pc_out[3:0]};
    if (halt_en && bus.pc_out == 8'd5) bus.instr_in[4:0] = 5'h1F;
  end

  function automatic logic [18:0] mem_word(input logic [7:0] a);
    return {6'h2A, a, 1'b0, a[3:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.start = 1'b0; bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 8'd0;
    halt_en = 1'b0;
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic start_run(input logic rdy);
    bus.start = 1'b1; bus.out_ready = rdy;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 8'd0;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_pc !== 8'd0) begin miscompares++; $display("FAIL reset_out_pc: got %0d want 0", bus.out_pc); end
    vectors++; if (bus.out_instr !== 19'd0) begin miscompares++; $display("FAIL reset_out_instr: got %h want 0", bus.out_instr); end
    vectors++; if (bus.pc_out !== 8'd0) begin miscompares++; $display("FAIL reset_pc_out: got %0d want 0", bus.pc_out); end
    vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    vectors++; if (bus.addr_err !== 1'b0) begin miscompares++; $display("FAIL reset_addr_err: got %b want 0", bus.addr_err); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (bus.out_valid !== 1'b0 || bus.pc_out !== 8'd0) begin miscompares++; $display("FAIL idle_no_fetch: got valid=%b pc_out=%0d want valid=0 pc_out=0", bus.out_valid, bus.pc_out); end
    end
  endtask

  task automatic test_sequential();
    do_reset();
    start_run(1'b1);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL seq_first_latency: got valid=%b want 0", bus.out_valid); end
    for (int k = 0; k < 6; k++) begin
      step();
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'(k) || bus.out_instr !== mem_word(8'(k))) begin miscompares++; $display("FAIL seq_stream: got valid=%b pc=%0d instr=%h want valid=1 pc=%0d instr=%h", bus.out_valid, bus.out_pc, bus.out_instr, k, mem_word(8'(k))); end
    end
  endtask

  task automatic test_redirect_wrap();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'd24, 8'd25, 8'd0, 8'd1};
    do_reset();
    start_run(1'b1);
    step(); step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'd24;
    step();
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0 || bus.pc_out !== 8'd24 || bus.addr_err !== 1'b0) begin miscompares++; $display("FAIL redir_flush: got valid=%b pc_out=%0d err=%b want valid=0 pc_out=24 err=0", bus.out_valid, bus.pc_out, bus.addr_err); end
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_seq[k] || bus.out_instr !== mem_word(exp_seq[k]) || bus.addr_err !== 1'b0) begin miscompares++; $display("FAIL redir_wrap_seq: got valid=%b pc=%0d err=%b want valid=1 pc=%0d err=0", bus.out_valid, bus.out_pc, bus.addr_err, exp_seq[k]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    start_run(1'b0);
    for (int i = 0; i < 5; i++) step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'd0 || bus.pc_out !== 8'd2) begin miscompares++; $display("FAIL stall_hold: got valid=%b out_pc=%0d pc_out=%0d want valid=1 out_pc=0 pc_out=2", bus.out_valid, bus.out_pc, bus.pc_out); end
    bus.out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'(k) || bus.out_instr !== mem_word(8'(k))) begin miscompares++; $display("FAIL stall_release: got valid=%b pc=%0d want valid=1 pc=%0d", bus.out_valid, bus.out_pc, k); end
    end
  endtask

  task automatic test_halt();
    do_reset();
    halt_en = 1'b1;
    start_run(1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'(k)) begin miscompares++; $display("FAIL halt_stream: got valid=%b pc=%0d want valid=1 pc=%0d", bus.out_valid, bus.out_pc, k); end
    end
    vectors++; if (bus.out_instr !== {6'h2A, 8'd5, 5'h1F} || bus.halted !== 1'b1 || bus.pc_out !== 8'd6) begin miscompares++; $display("FAIL halt_word: got instr=%h halted=%b pc_out=%0d want instr=%h halted=1 pc_out=6", bus.out_instr, bus.halted, bus.pc_out, {6'h2A, 8'd5, 5'h1F}); end
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++; if (bus.out_valid !== 1'b0 || bus.halted !== 1'b1 || bus.pc_out !== 8'd6) begin miscompares++; $display("FAIL halt_stopped: got valid=%b halted=%b pc_out=%0d want valid=0 halted=1 pc_out=6", bus.out_valid, bus.halted, bus.pc_out); end
    end
    halt_en = 1'b0;
    start_run(1'b1);
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'd6 || bus.halted !== 1'b0) begin miscompares++; $display("FAIL halt_resume: got valid=%b pc=%0d halted=%b want valid=1 pc=6 halted=0", bus.out_valid, bus.out_pc, bus.halted); end
  endtask

  task automatic test_redirect_oob();
    do_reset();
    start_run(1'b0);
    step(); step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'd30; bus.out_ready = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0 || bus.addr_err !== 1'b1 || bus.pc_out !== 8'd0) begin miscompares++; $display("FAIL oob_flush: got valid=%b err=%b pc_out=%0d want valid=0 err=1 pc_out=0", bus.out_valid, bus.addr_err, bus.pc_out); end
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'd0 || bus.addr_err !== 1'b0) begin miscompares++; $display("FAIL oob_restart: got valid=%b pc=%0d err=%b want valid=1 pc=0 err=0", bus.out_valid, bus.out_pc, bus.addr_err); end
  endtask

  task automatic test_idle_redirect();
    do_reset();
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'd10;
    step();
    bus.redirect_valid = 1'b0;
    step(); step();
    vectors++; if (bus.out_valid !== 1'b0 || bus.pc_out !== 8'd10) begin miscompares++; $display("FAIL idle_redir_stay: got valid=%b pc_out=%0d want valid=0 pc_out=10", bus.out_valid, bus.pc_out); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'd3; bus.start = 1'b1;
    step();
    bus.redirect_valid = 1'b0; bus.start = 1'b0;
    vectors++; if (bus.pc_out !== 8'd3 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_redir_start_pc: got pc_out=%0d valid=%b want 3 valid=0", bus.pc_out, bus.out_valid); end
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'd3) begin miscompares++; $display("FAIL idle_redir_start_run: got valid=%b pc=%0d want valid=1 pc=3", bus.out_valid, bus.out_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_run(1'b0);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0 || bus.halted !== 1'b0 || bus.pc_out !== 8'd0 || bus.out_pc !== 8'd0) begin miscompares++; $display("FAIL midreset_clear: got valid=%b halted=%b pc_out=%0d out_pc=%0d want 0 0 0 0", bus.out_valid, bus.halted, bus.pc_out, bus.out_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (bus.out_valid !== 1'b0 || bus.pc_out !== 8'd0 || bus.addr_err !== 1'b0) begin miscompares++; $display("FAIL midreset_idle: got valid=%b pc_out=%0d err=%b want 0 0 0", bus.out_valid, bus.pc_out, bus.addr_err); end
    end
    start_run(1'b1);
    step();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'd0) begin miscompares++; $display("FAIL midreset_restart: got valid=%b pc=%0d want valid=1 pc=0", bus.out_valid, bus.out_pc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_redirect_wrap();
    test_backpressure();
    test_halt();
    test_redirect_oob();
    test_idle_redirect();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
